game_phase_controller: RTL and testbench
========================================

# game_phase_controller

Sequences the game through its three phases (start screen, play, end screen) and owns the round countdown. It replaces the sticky start latch and the ad-hoc end condition in the top level. It drives the display/LED/7-seg source selection, `time_left` for scoring, and a one-shot seed for the item random generator. It sits between the raw centre button, the map's `orders_done` vector and every phase-dependent mux in the top level.

## Interface
Parameters:
- `TICK_DIV`, 100_000_000: `basys_clk` cycles per game second.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles the synchronised button must be stable before its level is accepted.
- `GAME_SECONDS`, 120: round length loaded into `time_left`; range 1..65535.
- `END_HOLD_SECONDS`, 3: minimum seconds in END before a press is accepted.

Ports:
- `basys_clk` in 1: the single clock, 100 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_start` in 1: raw btnC, asynchronous.
- `orders_done` in 3: one-hot completion flags from the map; `3'b111` means all orders are done.
- `phase` out 2: current phase, IDLE/PLAY/END.
- `start_game` out 1: high when phase is PLAY.
- `game_end` out 1: high when phase is END.
- `time_left` out 16: remaining seconds.
- `sec_pulse` out 1: one-cycle strobe on every PLAY second boundary.
- `seed` out 32: random-generator seed.
- `seed_valid` out 1: high once `seed` is loaded.

## Operation
- **Button path:**
  - 2-flop synchroniser feeds a debounce counter. The counter reloads on any change and updates the debounced level after `DEBOUNCE_CYCLES` stable cycles.
  - `press` is a one-cycle pulse on the debounced rising edge only. Holding the button gives exactly one press.
- **Free-running 32-bit counter:** increments every cycle from reset; used only for the seed.
- **State machine:**
  - IDLE -> PLAY on `press`. Same cycle: `time_left <= GAME_SECONDS`, second counter cleared, seed captured.
  - PLAY -> END when `orders_done == 3'b111`, or when a second boundary decrements `time_left` from 1 to 0. `press` is ignored in PLAY.
  - END: the hold counter counts seconds up to `END_HOLD_SECONDS`. A `press` before that is discarded, not queued. END -> IDLE on `press` after the hold.
- **Seed rules:**
  - `seed` = `32'hFACEB10C` (the generator's "not loaded" sentinel) until the first IDLE->PLAY transition.
  - At that transition `seed` takes the free-running counter value. If that value equals the sentinel, `seed` takes `32'h0000_0001` instead.
  - `seed_valid` goes high and `seed` is held until reset. Later rounds do not reseed.
- **`time_left` rules:**
  - Equals `GAME_SECONDS` in IDLE.
  - Decrements in PLAY.
  - Frozen in END, so the final value is available to scoring.
  - Never wraps below 0.
- **Simultaneous events:** `orders_done == 3'b111` on the same cycle as a second boundary gives END with `time_left` not decremented (completion wins).
- **Out-of-range parameter:** `GAME_SECONDS == 0` is illegal; the implementation asserts on it in simulation.

## Timing
- **Reset values:** `phase` = IDLE, `start_game` = 0, `game_end` = 0, `time_left` = `GAME_SECONDS`, `sec_pulse` = 0, `seed` = `32'hFACEB10C`, `seed_valid` = 0. All internal counters are 0 and the debounced level is 0.
- **Button latency:** a button edge produces `press` 2 + `DEBOUNCE_CYCLES` cycles later (±1). `phase` and all outputs are registered and change on the cycle after `press`.
- **Second boundary:** occurs every `TICK_DIV` cycles counted from PLAY entry. The first `sec_pulse` comes `TICK_DIV` cycles after entry. On the cycle `sec_pulse` is high, `time_left` shows the decremented value.
- **Entering END:** `game_end` rises the cycle after the end condition. `sec_pulse` never fires outside PLAY.
- **Reset mid-round:** `reset_n` low at any time forces the reset values immediately (asynchronous), including discarding the seed.

## Structure
- **Shared package (`game_pkg`):**
  - `phase_t` enum: IDLE = 2'd0, PLAY = 2'd1, END = 2'd2; 2'd3 is unreachable and recovers to IDLE.
  - `SEED_SENTINEL` = `32'hFACEB10C`.
  - `ALL_ORDERS` = `3'b111`.
- **Sub-module:** one, `btn_debounce`, containing the synchroniser, the stable counter and the rising-edge pulse. It is reusable for btnU/D/L/R.
- **Everything else is flat in this module:** FSM, second prescaler, `time_left`, hold counter, seed capture.

## Test plan
Bench parameters: `TICK_DIV` = 10, `DEBOUNCE_CYCLES` = 4, `GAME_SECONDS` = 3, `END_HOLD_SECONDS` = 1.
- **Bounce rejection:** toggle `btn_start` every 2 cycles for 20 cycles, then hold high -> exactly one `press`. `phase` goes PLAY about 7 cycles after the final rising edge. A further 50 cycles held high -> no second press.
- **Timeout:** enter PLAY and hold `orders_done` = 0 -> `time_left` steps 3,2,1,0 with `sec_pulse` every 10 cycles. `game_end` = 1 one cycle after reaching 0, and `time_left` stays 0.
- **Completion, including the tie:** in PLAY, drive `orders_done` = `3'b111` at cycle 15 -> END with `time_left` = 2. Repeat with the assertion landing exactly on a second boundary -> END with `time_left` not decremented.
- **End hold and restart:** a press in END 5 cycles after entry -> ignored, phase stays END. A press after 12 cycles -> IDLE, `time_left` = 3, `seed` unchanged.
- **Seed:**
  - After reset, `seed` = `32'hFACEB10C` and `seed_valid` = 0.
  - First press -> `seed` equals the free-running count and `seed_valid` = 1.
  - Force the counter to the sentinel at capture -> `seed` = `32'h00000001`.
- **Reset mid-round:** drop `reset_n` in PLAY with `time_left` = 1 -> immediately `phase` = IDLE, `time_left` = 3, `seed_valid` = 0, `sec_pulse` = 0.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the game phase logic.
//               phase_t  - IDLE / PLAY / END phase encoding (2'd3 unused)
//               SEED_SENTINEL - "seed not loaded" marker of the item RNG
//               ALL_ORDERS    - orders_done value meaning every order is done
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    END  = 2'd2
  } phase_t;

  localparam logic [31:0] SEED_SENTINEL = 32'hFACEB10C;
  localparam logic [2:0]  ALL_ORDERS    = 3'b111;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Push-button conditioner: 2-flop synchroniser, stable-level
//               counter and debounced rising-edge pulse.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               i_btn    - raw asynchronous button level
//               o_press  - one-cycle pulse on each accepted rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_level;
  logic               r_press;

  // The counter only runs while the synchronised input differs from the
  // accepted level; any return to the accepted level restarts the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/game_phase_controller.sv
`default_nettype none
// ============================================================================
// Module      : game_phase_controller
// Description : Start/play/end phase sequencer with round countdown, end-of-
//               round hold-off and one-shot random seed capture.
// Ports       : basys_clk   - 100 MHz system clock
//               reset_n     - asynchronous active-low reset
//               btn_start   - raw centre button
//               orders_done - per-order completion flags (3'b111 = all done)
//               phase       - current phase (IDLE/PLAY/END)
//               start_game  - high in PLAY
//               game_end    - high in END
//               time_left   - remaining round seconds
//               sec_pulse   - one-cycle strobe per PLAY second
//               seed        - random generator seed
//               seed_valid  - seed has been captured
// Revision    : 1.0 - initial release
// ============================================================================
module game_phase_controller
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV         = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
  parameter int unsigned GAME_SECONDS     = 120,
  parameter int unsigned END_HOLD_SECONDS = 3
) (
  input  logic        basys_clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic [2:0]  orders_done,
  output logic [1:0]  phase,
  output logic        start_game,
  output logic        game_end,
  output logic [15:0] time_left,
  output logic        sec_pulse,
  output logic [31:0] seed,
  output logic        seed_valid
);

  localparam int unsigned c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
  localparam logic [15:0] c_game_seconds = 16'(GAME_SECONDS);
  localparam logic [15:0] c_end_hold     = 16'(END_HOLD_SECONDS);
  localparam logic [31:0] c_seed_fallback = 32'h0000_0001;

  phase_t              r_phase;
  logic                r_start_game;
  logic                r_game_end;
  logic [15:0]         r_time_left;
  logic                r_sec_pulse;
  logic [31:0]         r_seed;
  logic                r_seed_valid;
  logic [c_tick_w-1:0] r_tick_cnt;
  logic [15:0]         r_hold_cnt;
  logic [31:0]         r_free_cnt;

  logic w_press;
  logic w_tick;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (basys_clk),
    .rst_n   (reset_n),
    .i_btn   (btn_start),
    .o_press (w_press)
  );

  // Seed entropy only: the press arrives at a human-random cycle count.
  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) r_free_cnt <= '0;
    else          r_free_cnt <= r_free_cnt + 32'd1;
  end

  // The prescaler is cleared on every phase entry, so in PLAY a boundary
  // falls every TICK_DIV cycles from entry and in END it paces the hold.
  assign w_tick = (r_tick_cnt == c_tick_last);

  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase      <= IDLE;
      r_start_game <= 1'b0;
      r_game_end   <= 1'b0;
      r_time_left  <= c_game_seconds;
      r_sec_pulse  <= 1'b0;
      r_seed       <= SEED_SENTINEL;
      r_seed_valid <= 1'b0;
      r_tick_cnt   <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_sec_pulse <= 1'b0;
      case (r_phase)
        IDLE: begin
          r_time_left <= c_game_seconds;
          r_tick_cnt  <= '0;
          r_hold_cnt  <= '0;
          if (w_press) begin
            r_phase      <= PLAY;
            r_start_game <= 1'b1;
            // Only the first round of a power-up seeds the generator; a raw
            // count equal to the sentinel would read as "not loaded".
            if (!r_seed_valid) begin
              r_seed       <= (r_free_cnt == SEED_SENTINEL) ? c_seed_fallback : r_free_cnt;
              r_seed_valid <= 1'b1;
            end
          end
        end
        PLAY: begin
          // Completion is checked before the boundary so a tie ends the
          // round without spending the second. A time_left of zero ends the
          // round one cycle after the boundary that produced it.
          if ((orders_done == ALL_ORDERS) || (r_time_left == 16'd0)) begin
            r_phase      <= END;
            r_start_game <= 1'b0;
            r_game_end   <= 1'b1;
            r_tick_cnt   <= '0;
          end else if (w_tick) begin
            r_tick_cnt  <= '0;
            r_sec_pulse <= 1'b1;
            r_time_left <= r_time_left - 16'd1;
          end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
          end
        end
        END: begin
          if (w_tick) begin
            r_tick_cnt <= '0;
            if (r_hold_cnt != c_end_hold) r_hold_cnt <= r_hold_cnt + 16'd1;
          end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
          end
          // Presses during the hold are simply dropped.
          if (w_press && (r_hold_cnt == c_end_hold)) begin
            r_phase     <= IDLE;
            r_game_end  <= 1'b0;
            r_time_left <= c_game_seconds;
          end
        end
        default: begin
          r_phase      <= IDLE;
          r_start_game <= 1'b0;
          r_game_end   <= 1'b0;
          r_time_left  <= c_game_seconds;
          r_tick_cnt   <= '0;
          r_hold_cnt   <= '0;
        end
      endcase
    end
  end

  assign phase      = r_phase;
  assign start_game = r_start_game;
  assign game_end   = r_game_end;
  assign time_left  = r_time_left;
  assign sec_pulse  = r_sec_pulse;
  assign seed       = r_seed;
  assign seed_valid = r_seed_valid;

  a_game_seconds_nonzero: assert property (@(posedge basys_clk) GAME_SECONDS != 0)
    else $error("game_phase_controller: GAME_SECONDS must be in 1..65535");

endmodule
`default_nettype wire

// File: tb/tb_game_phase_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_phase_controller
// Description : Self-checking bench for game_phase_controller with short
//               timing parameters (tick 10, debounce 4, 3 s round, 1 s hold).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_phase_controller;
  import game_pkg::*;

  localparam int unsigned c_tick     = 10;
  localparam int unsigned c_debounce = 4;
  localparam int unsigned c_seconds  = 3;
  localparam int unsigned c_hold     = 1;

  logic        basys_clk;
  logic        reset_n;
  logic        btn_start;
  logic [2:0]  orders_done;
  logic [1:0]  phase;
  logic        start_game;
  logic        game_end;
  logic [15:0] time_left;
  logic        sec_pulse;
  logic [31:0] seed;
  logic        seed_valid;

  game_phase_controller #(
    .TICK_DIV         (c_tick),
    .DEBOUNCE_CYCLES  (c_debounce),
    .GAME_SECONDS     (c_seconds),
    .END_HOLD_SECONDS (c_hold)
  ) u_dut (
    .basys_clk   (basys_clk),
    .reset_n     (reset_n),
    .btn_start   (btn_start),
    .orders_done (orders_done),
    .phase       (phase),
    .start_game  (start_game),
    .game_end    (game_end),
    .time_left   (time_left),
    .sec_pulse   (sec_pulse),
    .seed        (seed),
    .seed_valid  (seed_valid)
  );

  initial basys_clk = 1'b0;
  always #5 basys_clk = ~basys_clk;

  typedef struct packed {
    logic [1:0]  phase;
    logic        start_game;
    logic        game_end;
    logic [15:0] time_left;
    logic        sec_pulse;
  } obs_t;

  typedef struct {
    logic       btn;
    logic [2:0] orders;
    int         wait_cyc;
    logic [1:0] phase;
    logic [15:0] tl;
    logic       pulse;
  } vec_t;

  int    compared;
  int    mismatched;
  int    press_cnt;
  obs_t  exp_q[$];
  string name_q[$];
  logic [31:0] bench_cyc;
  logic [31:0] first_seed;
  vec_t  tbl[8];

  // Reference cycle count since reset release, the same count a seed takes.
  always @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) bench_cyc <= 32'd0;
    else          bench_cyc <= bench_cyc + 32'd1;
  end

  always @(negedge basys_clk) begin
    if (reset_n && u_dut.u_btn.o_press) press_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk_obs(input logic [1:0] p, input logic [15:0] tl, input logic pulse);
    obs_t o;
    o.phase      = p;
    o.start_game = (p == PLAY);
    o.game_end   = (p == END);
    o.time_left  = tl;
    o.sec_pulse  = pulse;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.phase      = phase;
    o.start_game = start_game;
    o.game_end   = game_end;
    o.time_left  = time_left;
    o.sec_pulse  = sec_pulse;
    return o;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge basys_clk);
  endtask

  task automatic push_exp(input string name, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic pop_check();
    obs_t  e;
    obs_t  a;
    string n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    a = sample();
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got phase=%0d sg=%0b ge=%0b tl=%0d sp=%0b, want phase=%0d sg=%0b ge=%0b tl=%0d sp=%0b",
               n, a.phase, a.start_game, a.game_end, a.time_left, a.sec_pulse,
               e.phase, e.start_game, e.game_end, e.time_left, e.sec_pulse);
    end
  endtask

  task automatic expect_after(input string name, input obs_t e, input int n);
    push_exp(name, e);
    tick(n);
    pop_check();
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_phase(input logic [1:0] p, input int max_cyc, input string name, output int n);
    n = 0;
    while (phase !== p && n < max_cyc) begin
      @(negedge basys_clk);
      n++;
    end
    if (phase !== p) begin
      compared++;
      mismatched++;
      $display("FAIL %s: phase=%0d after %0d cycles, want %0d", name, phase, n, p);
    end
  endtask

  initial begin
    int n;
    compared    = 0;
    mismatched  = 0;
    press_cnt   = 0;
    reset_n     = 1'b0;
    btn_start   = 1'b0;
    orders_done = 3'b000;

    // Timeout round, t = cycles since PLAY entry: {btn, orders, wait, phase, time_left, sec_pulse}
    tbl[0] = '{1'b1, 3'b000, 0,  PLAY, 16'd3, 1'b0};
    tbl[1] = '{1'b1, 3'b000, 9,  PLAY, 16'd3, 1'b0};
    tbl[2] = '{1'b1, 3'b000, 1,  PLAY, 16'd2, 1'b1};
    tbl[3] = '{1'b1, 3'b000, 1,  PLAY, 16'd2, 1'b0};
    tbl[4] = '{1'b1, 3'b000, 9,  PLAY, 16'd1, 1'b1};
    tbl[5] = '{1'b1, 3'b000, 10, PLAY, 16'd0, 1'b1};
    tbl[6] = '{1'b1, 3'b000, 1,  END,  16'd0, 1'b0};
    tbl[7] = '{1'b1, 3'b000, 20, END,  16'd0, 1'b0};

    // Reset state
    expect_after("reset_state", mk_obs(IDLE, 16'd3, 1'b0), 3);
    check_val("reset_seed", seed, SEED_SENTINEL);
    check_val("reset_seed_valid", {31'd0, seed_valid}, 32'd0);
    reset_n = 1'b1;
    tick(3);

    // Bounce rejection, then a steady press
    for (int i = 0; i < 20; i++) begin
      btn_start = ((i / 2) % 2 == 0);
      tick(1);
    end
    check_val("bounce_no_press", phase, IDLE);
    btn_start = 1'b1;
    wait_phase(PLAY, 12, "bounce_enter_play", n);
    compared++;
    if (n < 6 || n > 8) begin
      mismatched++;
      $display("FAIL press_latency: got %0d cycles, want 6..8", n);
    end
    first_seed = bench_cyc - 32'd1;
    check_val("first_seed", seed, first_seed);
    check_val("first_seed_valid", {31'd0, seed_valid}, 32'd1);

    // Timeout round with the button still held
    for (int i = 0; i < 8; i++) begin
      btn_start   = tbl[i].btn;
      orders_done = tbl[i].orders;
      expect_after($sformatf("timeout_row%0d", i), mk_obs(tbl[i].phase, tbl[i].tl, tbl[i].pulse), tbl[i].wait_cyc);
    end
    check_val("held_single_press", press_cnt, 32'd1);

    // Restart from END after the hold
    btn_start = 1'b0;
    tick(8);
    btn_start = 1'b1;
    wait_phase(IDLE, 12, "restart_idle", n);
    expect_after("restart_state", mk_obs(IDLE, 16'd3, 1'b0), 0);
    check_val("restart_seed", seed, first_seed);

    // Completion at t=15
    btn_start = 1'b0;
    tick(8);
    btn_start = 1'b1;
    wait_phase(PLAY, 12, "complete_enter", n);
    btn_start = 1'b0;
    check_val("no_reseed", seed, first_seed);
    expect_after("complete_pre", mk_obs(PLAY, 16'd2, 1'b0), 15);
    orders_done = ALL_ORDERS;
    expect_after("complete_end", mk_obs(END, 16'd2, 1'b0), 1);
    orders_done = 3'b000;

    // Press during the END hold is dropped, later press restarts
    btn_start = 1'b1;
    expect_after("hold_press_ignored", mk_obs(END, 16'd2, 1'b0), 12);
    btn_start = 1'b0;
    tick(8);
    btn_start = 1'b1;
    wait_phase(IDLE, 12, "hold_restart", n);
    expect_after("hold_restart_state", mk_obs(IDLE, 16'd3, 1'b0), 0);
    check_val("hold_restart_seed", seed, first_seed);

    // Completion tied with the first second boundary
    btn_start = 1'b0;
    tick(8);
    btn_start = 1'b1;
    wait_phase(PLAY, 12, "tie_enter", n);
    btn_start = 1'b0;
    tick(9);
    orders_done = ALL_ORDERS;
    expect_after("tie_end", mk_obs(END, 16'd3, 1'b0), 1);
    orders_done = 3'b000;

    // Asynchronous reset mid-round
    tick(12);
    btn_start = 1'b1;
    wait_phase(IDLE, 12, "rst_round_idle", n);
    btn_start = 1'b0;
    tick(8);
    btn_start = 1'b1;
    wait_phase(PLAY, 12, "rst_round_play", n);
    btn_start = 1'b0;
    expect_after("rst_pre", mk_obs(PLAY, 16'd1, 1'b1), 20);
    reset_n = 1'b0;
    #1;
    expect_after("rst_async_state", mk_obs(IDLE, 16'd3, 1'b0), 0);
    check_val("rst_seed", seed, SEED_SENTINEL);
    check_val("rst_seed_valid", {31'd0, seed_valid}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Free-running count equal to the sentinel at capture
    force u_dut.r_free_cnt = SEED_SENTINEL;
    btn_start = 1'b1;
    wait_phase(PLAY, 12, "sentinel_enter", n);
    release u_dut.r_free_cnt;
    btn_start = 1'b0;
    check_val("sentinel_seed", seed, 32'h0000_0001);
    check_val("sentinel_seed_valid", {31'd0, seed_valid}, 32'd1);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
